wt_dcache_rd_arb: RTL and testbench

WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

---
 rtl/wt_cache_pkg.sv | 18 +
 rtl/wt_dcache_rd_arb_rr.sv | 39 +++
 rtl/wt_dcache_rd_arb.sv | 125 ++++++++++++
 tb/tb_wt_dcache_rd_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wt_cache_pkg
//  Description : Geometry constants of the write-through data cache that are
//                shared by the cache sub-blocks (index, offset, tag widths and
//                associativity).
//  Revision    : 1.0 - initial release
// ============================================================================
package wt_cache_pkg;

    localparam int unsigned DCACHE_SET_ASSOC    = 8;
    localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;

endpackage : wt_cache_pkg
`default_nettype wire

// File: rtl/wt_dcache_rd_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : wt_dcache_rd_arb_rr
//  Description : Round-robin priority search. Returns the first requesting
//                port found searching upward (with wrap) from i_last+1; the
//                previous winner i_last has the lowest priority.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_req  [NumPorts]  : request vector
//    i_last [NumPortsW] : port that won the previous accepted arbitration
//    o_sel  [NumPortsW] : selected port (i_last when nothing requests)
// ============================================================================
module wt_dcache_rd_arb_rr #(
    parameter int unsigned NumPorts  = 3,
    parameter int unsigned NumPortsW = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0]  i_req,
    input  logic [NumPortsW-1:0] i_last,
    output logic [NumPortsW-1:0] o_sel
);

    logic [NumPortsW-1:0] w_cand;

    // Walk from the lowest to the highest priority position so that the
    // last hit written is the highest-priority requester.
    always_comb begin
        o_sel  = i_last;
        w_cand = '0;
        for (int k = NumPorts; k >= 1; k--) begin
            w_cand = NumPortsW'((int'(i_last) + k) % NumPorts);
            if (i_req[w_cand]) begin
                o_sel = w_cand;
            end
        end
    end

endmodule : wt_dcache_rd_arb_rr
`default_nettype wire

// File: rtl/wt_dcache_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : wt_dcache_rd_arb
//  Description : Read-port arbiter in front of the data-cache memory. Selects
//                one of NumPorts requesters round-robin, holds the selection
//                while the memory stalls, and routes the one-cycle-late tag
//                and the memory response back to the accepted port.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i, rst_ni            : clock, asynchronous active-low reset
//    rd_req_i/idx/off/tag_only: per-port request (held until acked)
//    rd_tag_i                 : per-port tag, valid the cycle after own ack
//    rd_ack_o                 : one-hot0 accept strobe (combinational)
//    rd_rvalid_o              : one-hot0 response-valid for the owning port
//    rd_data/vld_bits/hit_oh_o: broadcast memory response
//    mem_req/idx/off/tag_only_o, mem_tag_o : memory read port request
//    mem_ack_i                : memory accepts the request this cycle
//    mem_data/vld_bits/hit_oh_i: memory response, one cycle after accept
// ============================================================================
module wt_dcache_rd_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts  = 3,
    parameter int unsigned NumPortsW = $clog2(NumPorts)
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [NumPorts-1:0]                                 rd_req_i,
    input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]        rd_idx_i,
    input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]        rd_off_i,
    input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]           rd_tag_i,
    input  logic [NumPorts-1:0]                                 rd_tag_only_i,
    output logic [NumPorts-1:0]                                 rd_ack_o,
    output logic [NumPorts-1:0]                                 rd_rvalid_o,
    output logic [63:0]                                         rd_data_o,
    output logic [DCACHE_SET_ASSOC-1:0]                         rd_vld_bits_o,
    output logic [DCACHE_SET_ASSOC-1:0]                         rd_hit_oh_o,
    output logic                                                mem_req_o,
    output logic [DCACHE_CL_IDX_WIDTH-1:0]                      mem_idx_o,
    output logic [DCACHE_OFFSET_WIDTH-1:0]                      mem_off_o,
    output logic                                                mem_tag_only_o,
    output logic [DCACHE_TAG_WIDTH-1:0]                         mem_tag_o,
    input  logic                                                mem_ack_i,
    input  logic [63:0]                                         mem_data_i,
    input  logic [DCACHE_SET_ASSOC-1:0]                         mem_vld_bits_i,
    input  logic [DCACHE_SET_ASSOC-1:0]                         mem_hit_oh_i
);

    logic [NumPortsW-1:0] r_rr;        // last accepted port (RR pointer)
    logic [NumPortsW-1:0] r_id;        // port accepted in the previous cycle
    logic [NumPortsW-1:0] r_lock_sel;  // port selected while memory stalled
    logic                 r_pend;      // response due this cycle
    logic                 r_lock;      // previous request was not accepted
    logic [NumPortsW-1:0] w_rr_sel;
    logic [NumPortsW-1:0] w_sel;
    logic                 w_accept;
    logic                 w_stall;

    wt_dcache_rd_arb_rr #(
        .NumPorts  (NumPorts),
        .NumPortsW (NumPortsW)
    ) u_rr (
        .i_req  (rd_req_i),
        .i_last (r_rr),
        .o_sel  (w_rr_sel)
    );

    // A stalled requester keeps the memory port; the lock only falls away
    // once that requester withdraws.
    assign w_sel    = (r_lock && rd_req_i[r_lock_sel]) ? r_lock_sel : w_rr_sel;
    assign mem_req_o = |rd_req_i;
    assign w_accept = mem_req_o & mem_ack_i;
    assign w_stall  = mem_req_o & ~mem_ack_i;

    assign mem_idx_o      = rd_idx_i[w_sel];
    assign mem_off_o      = rd_off_i[w_sel];
    assign mem_tag_only_o = rd_tag_only_i[w_sel];
    // Tag arrives one cycle after the index, so it follows the accepted id.
    assign mem_tag_o      = rd_tag_i[r_id];

    assign rd_data_o     = mem_data_i;
    assign rd_vld_bits_o = mem_vld_bits_i;
    assign rd_hit_oh_o   = mem_hit_oh_i;

    generate
        for (genvar i = 0; i < NumPorts; i++) begin : g_port
            // Ack is gated by reset so a memory ack during reset never
            // reaches a requester.
            assign rd_ack_o[i]    = rst_ni & w_accept & (w_sel == NumPortsW'(i));
            assign rd_rvalid_o[i] = r_pend & (r_id == NumPortsW'(i));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= NumPortsW'(NumPorts - 1);
            r_id       <= '0;
            r_lock_sel <= '0;
            r_pend     <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_pend <= w_accept;
            r_lock <= w_stall;
            if (w_accept) begin
                r_rr <= w_sel;
                r_id <= w_sel;
            end
            if (w_stall) begin
                r_lock_sel <= w_sel;
            end
        end
    end

`ifndef SYNTHESIS
    a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rd_ack_o));
    a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rd_rvalid_o));
    a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_lock && rd_req_i[r_lock_sel]) |-> (w_sel == r_lock_sel));
`endif

endmodule : wt_dcache_rd_arb
`default_nettype wire

// File: tb/tb_wt_dcache_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wt_dcache_rd_arb
//  Description : Scoreboard testbench for wt_dcache_rd_arb. A stimulus
//                process drives requests and predicts grants with a simple
//                round-robin/lock model; a monitor pops expectations when the
//                DUT presents a request or a response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wt_dcache_rd_arb;
    import wt_cache_pkg::*;

    localparam int NP   = 3;
    localparam int NPW  = $clog2(NP);
    localparam int IDXW = DCACHE_CL_IDX_WIDTH;
    localparam int OFFW = DCACHE_OFFSET_WIDTH;
    localparam int TAGW = DCACHE_TAG_WIDTH;
    localparam int ASC  = DCACHE_SET_ASSOC;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b0;
    logic [NP-1:0]              rd_req_i = '0;
    logic [NP-1:0][IDXW-1:0]    rd_idx_i = '0;
    logic [NP-1:0][OFFW-1:0]    rd_off_i = '0;
    logic [NP-1:0][TAGW-1:0]    rd_tag_i = '0;
    logic [NP-1:0]              rd_tag_only_i = '0;
    logic [NP-1:0]              rd_ack_o;
    logic [NP-1:0]              rd_rvalid_o;
    logic [63:0]                rd_data_o;
    logic [ASC-1:0]             rd_vld_bits_o;
    logic [ASC-1:0]             rd_hit_oh_o;
    logic                       mem_req_o;
    logic [IDXW-1:0]            mem_idx_o;
    logic [OFFW-1:0]            mem_off_o;
    logic                       mem_tag_only_o;
    logic [TAGW-1:0]            mem_tag_o;
    logic                       mem_ack_i = 1'b0;
    logic [63:0]                mem_data_i = '0;
    logic [ASC-1:0]             mem_vld_bits_i = '0;
    logic [ASC-1:0]             mem_hit_oh_i = '0;

    wt_dcache_rd_arb #(.NumPorts(NP), .NumPortsW(NPW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rd_req_i       (rd_req_i),
        .rd_idx_i       (rd_idx_i),
        .rd_off_i       (rd_off_i),
        .rd_tag_i       (rd_tag_i),
        .rd_tag_only_i  (rd_tag_only_i),
        .rd_ack_o       (rd_ack_o),
        .rd_rvalid_o    (rd_rvalid_o),
        .rd_data_o      (rd_data_o),
        .rd_vld_bits_o  (rd_vld_bits_o),
        .rd_hit_oh_o    (rd_hit_oh_o),
        .mem_req_o      (mem_req_o),
        .mem_idx_o      (mem_idx_o),
        .mem_off_o      (mem_off_o),
        .mem_tag_only_o (mem_tag_only_o),
        .mem_tag_o      (mem_tag_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i),
        .mem_vld_bits_i (mem_vld_bits_i),
        .mem_hit_oh_i   (mem_hit_oh_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int              cyc;
        int              port;
        logic            acc;
        logic [IDXW-1:0] idx;
        logic [OFFW-1:0] off;
        logic            to;
    } req_exp_t;

    typedef struct {
        int              cyc;
        int              port;
        logic [TAGW-1:0] tag;
        logic [63:0]     data;
        logic [ASC-1:0]  vld;
        logic [ASC-1:0]  hit;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    logic in_reset   = 1'b1;

    // Reference model state: plain integers, -1 meaning "none".
    int   m_last     = NP - 1;
    int   m_lock     = -1;
    int   m_prev_acc = -1;
    logic [NP-1:0]   m_prev_req = '0;
    logic [IDXW-1:0] p_idx [NP];
    logic [OFFW-1:0] p_off [NP];
    logic            p_to  [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] req, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (req[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    task automatic step(input logic [NP-1:0] req, input logic ack);
        int cand;
        req_exp_t re;
        rsp_exp_t rs;
        @(posedge clk_i);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            // A request presents a new payload when it starts or after being acked.
            if (req[p] && (!m_prev_req[p] || m_prev_acc == p)) begin
                p_idx[p] = IDXW'($urandom);
                p_off[p] = OFFW'($urandom);
                p_to[p]  = 1'($urandom);
            end
            rd_idx_i[p]      = p_idx[p];
            rd_off_i[p]      = p_off[p];
            rd_tag_only_i[p] = p_to[p];
            rd_tag_i[p]      = TAGW'({$urandom, $urandom});
        end
        rd_req_i       = req;
        mem_ack_i      = ack;
        mem_data_i     = {$urandom, $urandom};
        mem_vld_bits_i = ASC'($urandom);
        mem_hit_oh_i   = ASC'($urandom);

        if (m_prev_acc >= 0) begin
            rs.cyc  = cyc;
            rs.port = m_prev_acc;
            rs.tag  = rd_tag_i[m_prev_acc];
            rs.data = mem_data_i;
            rs.vld  = mem_vld_bits_i;
            rs.hit  = mem_hit_oh_i;
            rsp_q.push_back(rs);
        end

        if (req != '0) begin
            cand = (m_lock >= 0 && req[m_lock]) ? m_lock : rr_pick(req, m_last);
            re.cyc  = cyc;
            re.port = cand;
            re.acc  = ack;
            re.idx  = p_idx[cand];
            re.off  = p_off[cand];
            re.to   = p_to[cand];
            req_q.push_back(re);
            if (ack) begin
                m_last     = cand;
                m_lock     = -1;
                m_prev_acc = cand;
            end else begin
                m_lock     = cand;
                m_prev_acc = -1;
            end
        end else begin
            m_lock     = -1;
            m_prev_acc = -1;
        end
        m_prev_req = req;
    endtask

    // Reset asserted mid-cycle while requests and a memory ack are present.
    task automatic do_reset();
        @(posedge clk_i);
        #1;
        cyc++;
        in_reset = 1'b1;
        rst_ni   = 1'b0;
        req_q.delete();
        rsp_q.delete();
        m_last = NP - 1;
        m_lock = -1;
        m_prev_acc = -1;
        m_prev_req = '0;
        rd_req_i  = '1;
        mem_ack_i = 1'b1;
        #2;
        chk("reset_ack", 64'(rd_ack_o), 64'(0));
        chk("reset_rvalid", 64'(rd_rvalid_o), 64'(0));
        chk("reset_mem_req", 64'(mem_req_o), 64'(1));
        rd_req_i  = '0;
        mem_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni   = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        req_exp_t re;
        rsp_exp_t rs;
        logic [NP-1:0] ev;
        forever begin
            @(posedge clk_i);
            #6;
            if (in_reset) continue;
            if (mem_req_o) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", 64'(mem_req_o), 64'(0));
                end else begin
                    re = req_q.pop_front();
                    ev = '0;
                    if (re.acc) ev[re.port] = 1'b1;
                    chk("req_cycle", 64'(cyc), 64'(re.cyc));
                    chk("rd_ack", 64'(rd_ack_o), 64'(ev));
                    chk("mem_idx", 64'(mem_idx_o), 64'(re.idx));
                    chk("mem_off", 64'(mem_off_o), 64'(re.off));
                    chk("mem_tag_only", 64'(mem_tag_only_o), 64'(re.to));
                end
            end else begin
                chk("ack_without_req", 64'(rd_ack_o), 64'(0));
                if (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
                    re = req_q.pop_front();
                    chk("missing_mem_req", 64'(mem_req_o), 64'(1));
                end
            end
            if (rd_rvalid_o != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rvalid", 64'(rd_rvalid_o), 64'(0));
                end else begin
                    rs = rsp_q.pop_front();
                    ev = '0;
                    ev[rs.port] = 1'b1;
                    chk("rsp_cycle", 64'(cyc), 64'(rs.cyc));
                    chk("rd_rvalid", 64'(rd_rvalid_o), 64'(ev));
                    chk("mem_tag", 64'(mem_tag_o), 64'(rs.tag));
                    chk("rd_data", rd_data_o, rs.data);
                    chk("rd_vld_bits", 64'(rd_vld_bits_o), 64'(rs.vld));
                    chk("rd_hit_oh", 64'(rd_hit_oh_o), 64'(rs.hit));
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                rs = rsp_q.pop_front();
                chk("missing_rvalid", 64'(rd_rvalid_o), 64'(1) << rs.port);
            end
        end
    end

    initial begin
        logic [NP-1:0] rq;
        rq = '0;
        repeat (2) @(posedge clk_i);
        do_reset();

        // All ports requesting with an always-ready memory: 0,1,2,0.
        repeat (4) step('1, 1'b1);

        // Port 1 stalls three cycles while port 2 joins, then is accepted.
        step(3'b010, 1'b0);
        step(3'b110, 1'b0);
        step(3'b110, 1'b0);
        step(3'b110, 1'b1);

        // Lock holds port 0 against a higher-priority late joiner (port 2).
        step(3'b001, 1'b0);
        step(3'b101, 1'b0);
        step(3'b101, 1'b1);

        // Locked port 0 withdraws: port 1 wins in the same cycle.
        step(3'b001, 1'b0);
        step(3'b011, 1'b0);
        step(3'b010, 1'b1);

        // Back-to-back accepts of ports 2 then 0: tags follow each by one cycle.
        step(3'b100, 1'b1);
        step(3'b001, 1'b1);
        step(3'b000, 1'b0);

        // Memory ack with no request is ignored.
        step(3'b000, 1'b1);

        // Reset in the cycle after an accept drops the pending response.
        step(3'b010, 1'b1);
        do_reset();
        step(3'b010, 1'b1);
        step(3'b011, 1'b1);
        step(3'b000, 1'b0);

        // Randomised traffic: requests held until acked, occasional withdraw.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (rq[p]) begin
                    if (m_prev_acc == p) rq[p] = 1'($urandom_range(0, 1));
                    else if ($urandom_range(0, 9) == 0) rq[p] = 1'b0;
                end else begin
                    rq[p] = ($urandom_range(0, 2) == 0);
                end
            end
            step(rq, $urandom_range(0, 3) != 0);
        end

        step('0, 1'b0);
        step('0, 1'b0);
        @(posedge clk_i);
        #7;
        chk("drain_req_queue", 64'(req_q.size()), 64'(0));
        chk("drain_rsp_queue", 64'(rsp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wt_dcache_rd_arb
`default_nettype wire
